// File: rtl/scroll_fetcher.sv
// Per-scanline horizontal scroll fetcher: reads scroll bytes from the scroll RAM and presents layer A/B offsets.
// Optional layer B fetch is enabled by defining SCROLL_FETCH_LAYERB_EN.
module scroll_fetcher (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_LINE_TRIG,
    input  logic [7:0]  i_VLINE,
    input  logic        i_ROWMODE,
    input  logic        i_CPU_HOLD,
    output logic [10:0] o_SCRRAM_ADDR,
    output logic        o_SCRRAM_RD_n,
    input  logic [7:0]  i_SCRRAM_DOUT,
    output logic [8:0]  o_HSCROLL_A,
    output logic [8:0]  o_HSCROLL_B,
    output logic        o_VALID,
    output logic        o_BUSY
);

`ifdef SCROLL_FETCH_LAYERB_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PRESENT} state_t;

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [7:0]  line, line_n;
    logic        pend, pend_n;
    logic [7:0]  pend_line, pend_line_n;
    logic [10:0] addr_n;
    logic        rd_n_n;
    logic        valid_n, busy_n;
    logic        start;
    logic [7:0]  eff_line;

    // Read issued last cycle; its data sits in the RAM output register now.
    logic        cap_vld;
    logic [1:0]  cap_idx;
    logic        last_cap;

    logic [7:0]  sh_a_lo;
    logic        sh_a_hi;
`ifdef SCROLL_FETCH_LAYERB_EN
    logic [7:0]  sh_b_lo;
    logic        sh_b_hi;
`endif

    assign eff_line = i_ROWMODE ? {i_VLINE[7:3], 3'b000} : i_VLINE;
    assign last_cap = cap_vld && (cap_idx == LAST_IDX);

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        line_n      = line;
        pend_n      = pend;
        pend_line_n = pend_line;
        addr_n      = o_SCRRAM_ADDR;
        rd_n_n      = 1'b1;
        valid_n     = 1'b0;
        start       = 1'b0;

        case (state)
            IDLE: ;
            PRESENT: begin
                valid_n = 1'b1;
                state_n = IDLE;
            end
            ISSUE: begin
                rd_n_n = 1'b0;
                addr_n = {1'b0, line, idx};
                idx_n  = idx + 2'd1;
                if (idx == LAST_IDX)
                    state_n = DRAIN;
            end
            DRAIN: begin
                if (last_cap)
                    state_n = PRESENT;
            end
            default: state_n = IDLE;
        endcase

        if ((state == IDLE || state == PRESENT) && (i_LINE_TRIG || pend) && !i_CPU_HOLD)
            start = 1'b1;

        // Starting drives idx 0 on the same edge, so ISSUE continues from idx 1.
        if (start) begin
            state_n = ISSUE;
            line_n  = pend ? pend_line : eff_line;
            rd_n_n  = 1'b0;
            addr_n  = {1'b0, line_n, 2'd0};
            idx_n   = 2'd1;
            pend_n  = pend && i_LINE_TRIG;
            if (pend && i_LINE_TRIG)
                pend_line_n = eff_line;
        end else if (i_LINE_TRIG && !pend) begin
            pend_n      = 1'b1;
            pend_line_n = eff_line;
        end

        busy_n = (state_n != IDLE) || pend_n || valid_n;
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            state         <= IDLE;
            idx           <= '0;
            line          <= '0;
            pend          <= 1'b0;
            pend_line     <= '0;
            o_SCRRAM_ADDR <= '0;
            o_SCRRAM_RD_n <= 1'b1;
            o_VALID       <= 1'b0;
            o_BUSY        <= 1'b0;
            cap_vld       <= 1'b0;
            cap_idx       <= '0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            line          <= line_n;
            pend          <= pend_n;
            pend_line     <= pend_line_n;
            o_SCRRAM_ADDR <= addr_n;
            o_SCRRAM_RD_n <= rd_n_n;
            o_VALID       <= valid_n;
            o_BUSY        <= busy_n;
            cap_vld       <= !o_SCRRAM_RD_n;
            cap_idx       <= o_SCRRAM_ADDR[1:0];
        end
    end

    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            sh_a_lo     <= '0;
            sh_a_hi     <= 1'b0;
            o_HSCROLL_A <= '0;
`ifdef SCROLL_FETCH_LAYERB_EN
            sh_b_lo     <= '0;
            sh_b_hi     <= 1'b0;
            o_HSCROLL_B <= '0;
`endif
        end else begin
            if (cap_vld) begin
                case (cap_idx)
                    2'd0: sh_a_lo <= i_SCRRAM_DOUT;
                    2'd1: sh_a_hi <= i_SCRRAM_DOUT[0];
`ifdef SCROLL_FETCH_LAYERB_EN
                    2'd2: sh_b_lo <= i_SCRRAM_DOUT;
                    2'd3: sh_b_hi <= i_SCRRAM_DOUT[0];
`endif
                    default: ;
                endcase
            end
            if (state == PRESENT) begin
                o_HSCROLL_A <= {sh_a_hi, sh_a_lo};
`ifdef SCROLL_FETCH_LAYERB_EN
                o_HSCROLL_B <= {sh_b_hi, sh_b_lo};
`endif
            end
        end
    end

`ifndef SCROLL_FETCH_LAYERB_EN
    assign o_HSCROLL_B = '0;
`endif

endmodule

// File: tb/tb_scroll_fetcher.sv
// Directed bench for scroll_fetcher with a registered scroll RAM model and a result scoreboard.
module tb_scroll_fetcher;

`ifdef SCROLL_FETCH_LAYERB_EN
    localparam int NB = 4;
`else
    localparam int NB = 2;
`endif
    localparam int LAT = NB + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trig = 1'b0;
    logic [7:0]  vline = '0;
    logic        rowmode = 1'b0;
    logic        hold = 1'b0;
    logic [10:0] addr;
    logic        rd_n;
    logic [7:0]  dout = '0;
    logic [8:0]  hs_a, hs_b;
    logic        valid, busy;

    logic [7:0] mem [0:2047];

    typedef struct { logic [8:0] a; logic [8:0] b; int e; } exp_t;
    typedef struct { logic [10:0] addr; int c; } rd_t;
    exp_t sb [$];
    rd_t  rdq [$];
    exp_t mx;

    int cyc = 0;
    int n_pass = 0;
    int n_checks = 0;
    int valid_cnt = 0;

    scroll_fetcher dut (
        .i_MCLK        (clk),
        .i_RST         (rst),
        .i_LINE_TRIG   (trig),
        .i_VLINE       (vline),
        .i_ROWMODE     (rowmode),
        .i_CPU_HOLD    (hold),
        .o_SCRRAM_ADDR (addr),
        .o_SCRRAM_RD_n (rd_n),
        .i_SCRRAM_DOUT (dout),
        .o_HSCROLL_A   (hs_a),
        .o_HSCROLL_B   (hs_b),
        .o_VALID       (valid),
        .o_BUSY        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!rd_n) dout <= mem[addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [8:0] exp_a(input logic [7:0] l);
        logic [10:0] b0 = {1'b0, l, 2'd0};
        logic [10:0] b1 = {1'b0, l, 2'd1};
        logic [7:0]  hi = mem[b1];
        return {hi[0], mem[b0]};
    endfunction

    function automatic logic [8:0] exp_b(input logic [7:0] l);
        logic [10:0] b2 = {1'b0, l, 2'd2};
        logic [10:0] b3 = {1'b0, l, 2'd3};
        logic [7:0]  hi = mem[b3];
        if (NB == 4) return {hi[0], mem[b2]};
        return 9'd0;
    endfunction

    task automatic push_exp(input logic [7:0] l, input int e);
        exp_t x;
        x.a = exp_a(l);
        x.b = exp_b(l);
        x.e = e;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (!rd_n) rdq.push_back('{addr, cyc});
            if (valid) begin
                valid_cnt++;
                if (sb.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
                else begin
                    mx = sb.pop_front();
                    check("hscroll_a", 32'(hs_a), 32'(mx.a));
                    check("hscroll_b", 32'(hs_b), 32'(mx.b));
                    check("valid_cycle", cyc, mx.e);
                    check("busy_with_valid", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic pulse_trig(input logic [7:0] v, input logic rm, output int e);
        @(negedge clk);
        vline = v;
        rowmode = rm;
        trig = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout_results_pending", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_addrs(input logic [7:0] l, input int e);
        rd_t r;
        logic [1:0] ii;
        for (int i = 0; i < NB; i++) begin
            ii = i[1:0];
            if (rdq.size() == 0) begin
                check("rd_missing", 32'd0, 32'd1);
                break;
            end
            r = rdq.pop_front();
            check("rd_addr", 32'(r.addr), 32'({1'b0, l, ii}));
            check("rd_cycle", r.c, e + i);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_rd_n", 32'(rd_n), 32'd1);
        check("rst_hs_a", 32'(hs_a), 32'd0);
        check("rst_hs_b", 32'(hs_b), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int e, e2;
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        mem[11'h094] = 8'h3C;
        mem[11'h095] = 8'hFF;
        mem[11'h096] = 8'h05;
        mem[11'h097] = 8'hFE;

        #1 rst = 1'b1;
        #2 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic fetch of line 0x25 (A = 0x13C, B = 0x005 with layer B).
        pulse_trig(8'h25, 1'b0, e);
        push_exp(8'h25, e + LAT);
        check("busy_during_fetch", 32'(busy), 32'd1);
        wait_done();
        check_addrs(8'h25, e);
        check("no_extra_reads", rdq.size(), 0);

        // Row mode: line 0x2F folds to 0x28.
        pulse_trig(8'h2F, 1'b1, e);
        push_exp(8'h28, e + LAT);
        wait_done();
        check_addrs(8'h28, e);
        rowmode = 1'b0;

        // CPU hold at trigger, released 10 cycles later.
        @(negedge clk);
        hold = 1'b1;
        pulse_trig(8'h41, 1'b0, e);
        for (int i = 0; i < 10; i++) begin
            check("hold_rd_n", 32'(rd_n), 32'd1);
            check("hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("hold_no_reads", rdq.size(), 0);
        hold = 1'b0;
        e = cyc + 1;
        push_exp(8'h41, e + LAT);
        wait_done();
        check_addrs(8'h41, e);

        // Second trigger at E+2 runs back-to-back after the first result.
        pulse_trig(8'h25, 1'b0, e);
        pulse_trig(8'h26, 1'b0, e2);
        check("second_trig_edge", e2, e + 2);
        push_exp(8'h25, e + LAT);
        push_exp(8'h26, e + 2 * LAT);
        wait_done();
        check_addrs(8'h25, e);
        check_addrs(8'h26, e + LAT);

        // Reset mid-fetch aborts with no result.
        pulse_trig(8'h25, 1'b0, e);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        sb.delete();
        rdq.delete();
        @(negedge clk);
        rst = 1'b0;
        valid_cnt = 0;
        repeat (10) @(negedge clk);
        check("no_valid_after_reset", valid_cnt, 0);
        check("no_reads_after_reset", rdq.size(), 0);

        // Normal operation after reset.
        pulse_trig(8'h25, 1'b0, e);
        push_exp(8'h25, e + LAT);
        wait_done();
        check_addrs(8'h25, e);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
